codeword_deserializer: RTL
==========================

CODEWORD_DESERIALIZER -- requirements
Module: codeword_deserializer

Interface
REQ-001 SHALL have parameter CW_WIDTH, default 9, codeword length in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port bit_in  input  1  serial channel bit.
REQ-005 SHALL have port bit_valid  input  1  bit_in is valid this cycle.
REQ-006 SHALL have port sof  input  1  start of frame; meaningful only when bit_valid=1; marks bit_in as the first bit of a codeword.
REQ-007 SHALL have port cx  output  CW_WIDTH  assembled codeword, presented to the downstream syndrome decoder.
REQ-008 SHALL have port cx_valid  output  1  cx holds a complete codeword.
REQ-009 SHALL have port cx_ready  input  1  downstream accepts cx this cycle.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse: completed word dropped.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: partial word aborted by sof.

Function
REQ-012 SHALL implement FSM states IDLE (no word in progress) and COLLECT (word in progress, bit counter cnt valid).
REQ-013 In IDLE, bit_valid=1 with sof=0 SHALL be ignored with no state change and no pulse.
REQ-014 In IDLE, bit_valid=1 with sof=1 SHALL store bit_in into shift position 0, set cnt=1 and enter COLLECT.
REQ-015 In COLLECT, bit_valid=1 with sof=0 SHALL store bit_in into position cnt and increment cnt.
REQ-016 Bit ordering SHALL be LSB-first: the k-th accepted bit of a word (k=0 first) lands in cx[k].
REQ-017 When the bit filling position CW_WIDTH-1 is accepted, the word SHALL be complete, cnt SHALL return to 0 and the FSM SHALL enter IDLE.
REQ-018 In COLLECT, bit_valid=0 SHALL hold all state; gaps of any length are allowed.
REQ-019 In COLLECT, bit_valid=1 with sof=1 SHALL discard the partial word, pulse frame_err for one cycle, and treat bit_in as bit 0 of a new word (cnt=1, stay in COLLECT).
REQ-020 On completion, if the output register is empty, or cx_valid=1 and cx_ready=1 in the same cycle, the complete word SHALL load into cx with cx_valid=1 on the next cycle and no overflow.
REQ-021 On completion, if cx_valid=1 and cx_ready=0, the new word SHALL be dropped, cx SHALL keep the held word, and overflow SHALL pulse for one cycle.
REQ-022 Without completion, cx_valid=1 and cx_ready=1 SHALL clear cx_valid next cycle; cx value after clearing is don't-care.
REQ-023 cx and cx_valid SHALL be driven from registers only, with no combinational path from any input to any output.
REQ-024 Latency SHALL be one cycle: the accepted last bit at edge N makes cx_valid=1 after edge N.
REQ-025 cx SHALL remain stable while cx_valid=1 and cx_ready=0.
REQ-026 Collection SHALL continue while the output is held; the only back-pressure consequence SHALL be REQ-021.
REQ-027 cnt width SHALL be clog2(CW_WIDTH+1) bits; cnt SHALL never exceed CW_WIDTH-1 in COLLECT.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously force FSM=IDLE, cnt=0, shift register=0, cx=0, cx_valid=0, overflow=0 and frame_err=0.
REQ-029 Reset asserted mid-word or with cx_valid=1 SHALL discard all data; the first word after release SHALL require a fresh sof.
REQ-030 Reset release SHALL be synchronised externally; the block SHALL start accepting bits on the first edge after release.

Verification
REQ-031 Word 9'b1_0110_0101 sent LSB-first with sof on the first bit, cx_ready=1 -> cx=9'h165, cx_valid=1 for exactly one cycle, the cycle after the 9th bit.
REQ-032 The same word with bit_valid toggling 0/1 every cycle -> identical cx; completes after 18 cycles.
REQ-033 4 bits then sof with a new 9-bit word 9'h0AA -> frame_err pulses once on the sof cycle; cx=9'h0AA; no overflow.
REQ-034 cx_ready=0 after word 9'h165, then second word 9'h0F0 completes -> overflow pulses once; cx stays 9'h165; raising cx_ready clears cx_valid.
REQ-035 cx_valid=1 and cx_ready=1 on the completion cycle of 9'h0F0 -> cx=9'h0F0, cx_valid stays 1, no overflow.
REQ-036 rst_n low after 5 bits, then bits without sof -> all outputs 0; bits ignored until the next sof.

Source files
------------

// File: rtl/codeword_deserializer.sv
// Serial-to-parallel codeword assembler: LSB-first bit collection framed by sof,
// single-entry output register with drop-on-full overflow and frame-abort reporting.
module codeword_deserializer #(
  parameter int unsigned CW_WIDTH = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bit_in,
  input  logic                bit_valid,
  input  logic                sof,
  output logic [CW_WIDTH-1:0] cx,
  output logic                cx_valid,
  input  logic                cx_ready,
  output logic                overflow,
  output logic                frame_err
);

  localparam int unsigned CNT_W = $clog2(CW_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(CW_WIDTH - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CW_WIDTH-1:0] shift_q, shift_d;
  logic [CW_WIDTH-1:0] cx_q, cx_d;
  logic                cx_valid_q, cx_valid_d;
  logic                overflow_q, overflow_d;
  logic                frame_err_q, frame_err_d;

  logic [CW_WIDTH-1:0] word_c;
  logic                word_done_c;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      cx_q        <= '0;
      cx_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      cx_q        <= cx_d;
      cx_valid_q  <= cx_valid_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state: bit collection, framing and output-register handoff
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    cx_d        = cx_q;
    cx_valid_d  = cx_valid_q;
    overflow_d  = 1'b0;
    frame_err_d = 1'b0;
    word_done_c = 1'b0;

    // Partial word with the current bit merged at position cnt
    word_c = shift_q;
    for (int unsigned i = 0; i < CW_WIDTH; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        word_c[i] = bit_in;
      end
    end

    case (state_q)
      IDLE: begin
        if (bit_valid && sof) begin
          shift_d    = '0;
          shift_d[0] = bit_in;
          cnt_d      = CNT_W'(1);
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (bit_valid) begin
          if (sof) begin
            frame_err_d = 1'b1;
            shift_d     = '0;
            shift_d[0]  = bit_in;
            cnt_d       = CNT_W'(1);
          end else if (cnt_q == LAST_POS) begin
            word_done_c = 1'b1;
            shift_d     = '0;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            shift_d = word_c;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase

    // A full register with no consumer this cycle drops the new word
    if (word_done_c) begin
      if (!cx_valid_q || cx_ready) begin
        cx_d       = word_c;
        cx_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (cx_valid_q && cx_ready) begin
      cx_valid_d = 1'b0;
    end
  end

  assign cx        = cx_q;
  assign cx_valid  = cx_valid_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
